// File: rtl/cache_pkg.sv
// Shared cache-hierarchy types and geometry helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Byte-address width for a memory of 'size' bytes.
  function automatic int unsigned addr_length(input int unsigned size);
    return 32'($clog2(size));
  endfunction

  // Offset bits selecting a byte within a block of 'block_bits' bits.
  function automatic int unsigned byte_select_size(input int unsigned block_bits);
    return 32'($clog2(block_bits / 8));
  endfunction

  // Number of block entries in a memory of 'size' bytes.
  function automatic int unsigned num_blocks(input int unsigned size, input int unsigned block_bits);
    return (size * 8) / block_bits;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Fixed-latency timer: cleared on request accept, counts while enabled,
// flags the cycle on which DELAY-1 is reached. Saturates, never wraps.
module delay_timer #(
  parameter int unsigned DELAY = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = $clog2(DELAY) + 1;
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

  logic [CW-1:0] count;

  // Count up while enabled, hold at the terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign done = start && (count == LAST);

endmodule

// File: rtl/block_memory_responder.sv
// Backing memory below the last cache level: answers block reads and
// accepts block write-backs after a fixed access latency.
module block_memory_responder
  import cache_pkg::*;
#(
  parameter int unsigned SIZE       = 4096,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned DELAY      = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [addr_length(SIZE)-1:0]  addr_in,
  input  logic [BLOCK_SIZE-1:0]         data_in,
  input  logic                          miss_in,
  input  logic                          wr_in,
  output logic [BLOCK_SIZE-1:0]         data_out,
  output logic                          req_out,
  output logic                          busy_out
);

  localparam int unsigned ADDR_LENGTH      = addr_length(SIZE);
  localparam int unsigned BYTE_SELECT_SIZE = byte_select_size(BLOCK_SIZE);
  localparam int unsigned NUM_BLOCKS       = num_blocks(SIZE, BLOCK_SIZE);
  localparam int unsigned IDX_W            = ADDR_LENGTH - BYTE_SELECT_SIZE;

  resp_state_t           state;
  resp_state_t           state_next;
  logic                  accept_c;
  logic                  complete_c;
  logic                  done;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic [BLOCK_SIZE-1:0] wdata_q;
  logic [BLOCK_SIZE-1:0] mem [NUM_BLOCKS];

  // Byte-offset bits do not select anything inside a block-wide entry.
  generate
    if (BYTE_SELECT_SIZE > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^addr_in[BYTE_SELECT_SIZE-1:0];
    end
  endgenerate

  // Access latency timer, cleared on accept and running only in WAIT.
  delay_timer #(.DELAY(DELAY)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept_c),
    .start (state == WAIT),
    .done  (done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a dropped miss_in during WAIT aborts the access.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    case (state)
      IDLE: begin
        if (miss_in) begin
          accept_c   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!miss_in) begin
          state_next = IDLE;
        end else if (done) begin
          complete_c = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (!miss_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture on accept; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept_c) begin
      idx_q   <= addr_in[ADDR_LENGTH-1:BYTE_SELECT_SIZE];
      wr_q    <= wr_in;
      wdata_q <= data_in;
    end
  end

  // Storage array: uncleared, written only when a write-back completes.
  always_ff @(posedge clk) begin
    if (complete_c && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Registered handshake and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_out  <= 1'b0;
      busy_out <= 1'b0;
      data_out <= '0;
    end else begin
      req_out  <= (state_next == RESP);
      busy_out <= (state_next != IDLE);
      if (complete_c) begin
        data_out <= wr_q ? wdata_q : mem[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench: a DELAY=20 and a DELAY=1 responder, scoreboarded.
module tb_block_memory_responder;

  localparam int unsigned SIZE = 512;
  localparam int unsigned BS   = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    addr;
  logic [BS-1:0] data_in;
  logic          wr;
  logic          miss0, miss1;
  logic [BS-1:0] d0, d1;
  logic          r0, r1, b0, b1;

  int checks = 0;
  int errors = 0;
  logic [BS-1:0] exp_q[$];

  always #5 clk = ~clk;

  block_memory_responder #(.SIZE(SIZE), .BLOCK_SIZE(BS), .DELAY(20)) dut0 (
    .clk(clk), .reset(reset), .addr_in(addr), .data_in(data_in),
    .miss_in(miss0), .wr_in(wr), .data_out(d0), .req_out(r0), .busy_out(b0)
  );

  block_memory_responder #(.SIZE(SIZE), .BLOCK_SIZE(BS), .DELAY(1)) dut1 (
    .clk(clk), .reset(reset), .addr_in(addr), .data_in(data_in),
    .miss_in(miss1), .wr_in(wr), .data_out(d1), .req_out(r1), .busy_out(b1)
  );

  // Full handshake: returns latency in edges after accept, response data,
  // busy right after accept, and req/busy one edge after miss drops.
  task automatic run_access(input bit which, input bit w, input logic [8:0] a,
                            input logic [BS-1:0] d, output int lat,
                            output logic [BS-1:0] got, output logic bsy_acc,
                            output logic rel, output logic bsy_end);
    @(negedge clk);
    addr = a; data_in = d; wr = w;
    if (which) miss1 = 1'b1; else miss0 = 1'b1;
    @(posedge clk);
    #1;
    bsy_acc = which ? b1 : b0;
    addr = ~a; data_in = ~d; wr = ~w;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) #1;
      if (k == 1) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      if ((which ? r1 : r0) === 1'b1) begin
        lat = k;
        break;
      end
    end
    got = which ? d1 : d0;
    @(negedge clk);
    if (which) miss1 = 1'b0; else miss0 = 1'b0;
    @(posedge clk); #1;
    rel     = which ? r1 : r0;
    bsy_end = which ? b1 : b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; miss0 = 1'b0; miss1 = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    #1;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL reset_req0 got %b exp 0", r0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b exp 0", b0); end
    checks++; if (d0 !== '0) begin errors++; $display("FAIL reset_data0 got %h exp 0", d0); end
    checks++; if (r1 !== 1'b0 || b1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got req=%b busy=%b exp 0/0", r1, b1); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_access(input string name, input bit which, input bit w,
                              input logic [8:0] a, input logic [BS-1:0] d,
                              input int exp_lat);
    int lat; logic [BS-1:0] got, exp; logic bsy_acc, rel, bsy_end;
    exp_q.push_back(w ? d : exp_q.size() == 0 ? '0 : '0);
    void'(exp_q.pop_back());
    exp_q.push_back(d);
    run_access(which, w, a, (w ? d : 32'h0BAD_0BAD), lat, got, bsy_acc, rel, bsy_end);
    exp = exp_q.pop_front();
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, exp_lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL %s_data got %h exp %h", name, got, exp); end
    checks++; if (bsy_acc !== 1'b1) begin errors++; $display("FAIL %s_busy_accept got %b exp 1", name, bsy_acc); end
    checks++; if (rel !== 1'b0 || bsy_end !== 1'b0) begin errors++; $display("FAIL %s_release got req=%b busy=%b exp 0/0", name, rel, bsy_end); end
  endtask

  task automatic test_write();
    check_access("write", 1'b0, 1'b1, 9'h050, 32'hDEAD_BEEF, 20);
  endtask

  task automatic test_read();
    check_access("read_same_block", 1'b0, 1'b0, 9'h052, 32'hDEAD_BEEF, 20);
  endtask

  task automatic test_other_block();
    check_access("write_other", 1'b0, 1'b1, 9'h054, 32'hA5A5_5A5A, 20);
    check_access("read_first", 1'b0, 1'b0, 9'h050, 32'hDEAD_BEEF, 20);
    check_access("read_other", 1'b0, 1'b0, 9'h057, 32'hA5A5_5A5A, 20);
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    addr = 9'h050; data_in = 32'h1111_1111; wr = 1'b1; miss0 = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    miss0 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (r0 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_req got req seen exp none"); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", b0); end
    check_access("read_after_abort", 1'b0, 1'b0, 9'h050, 32'hDEAD_BEEF, 20);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    addr = 9'h050; data_in = 32'h1234_5678; wr = 1'b1; miss0 = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (b0 !== 1'b0 || r0 !== 1'b0) begin errors++; $display("FAIL wait_reset got busy=%b req=%b exp 0/0", b0, r0); end
    miss0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_access("read_after_wait_reset", 1'b0, 1'b0, 9'h050, 32'hDEAD_BEEF, 20);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge clk);
    addr = 9'h050; wr = 1'b0; miss0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (r0 === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || d0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrun_resp got req=%b data=%h exp 1/deadbeef", r0, d0); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (r0 !== 1'b0 || b0 !== 1'b0 || d0 !== '0) begin
      errors++; $display("FAIL midrun_reset got req=%b busy=%b data=%h exp 0/0/0", r0, b0, d0);
    end
    miss0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_delay_one();
    check_access("d1_write", 1'b1, 1'b1, 9'h010, 32'hCAFE_F00D, 1);
    check_access("d1_read", 1'b1, 1'b0, 9'h013, 32'hCAFE_F00D, 1);
    check_access("d1_back_to_back", 1'b1, 1'b0, 9'h011, 32'hCAFE_F00D, 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_other_block();
    test_abort();
    test_reset_in_wait();
    test_reset_mid_run();
    test_delay_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
